// File: rtl/seq_mag_comp.sv
// Iterative MSB-first magnitude comparator: DIGIT bits per cycle, unsigned or signed,
// start/busy/done handshake with optional early termination on the first differing digit.
module seq_mag_comp #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DIGIT      = 2,
    parameter bit          EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             signed_mode_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             gt_o,
    output logic             eq_o,
    output logic             lt_o
);

    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned IdxW = (NDIG > 1) ? $clog2(NDIG) : 1;

    if (WIDTH % DIGIT != 0) begin : g_bad_digit
        $error("seq_mag_comp: WIDTH must be a multiple of DIGIT");
    end

    typedef enum logic [1:0] {StIdle, StCmp, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              diff_q, diff_d;
    logic              sgt_q, sgt_d;
    logic              gt_q, gt_d, eq_q, eq_d, lt_q, lt_d;

    logic [DIGIT-1:0]  dig_a, dig_b;
    logic              differ, dig_gt, last, fin_diff, fin_gt;
    logic [WIDTH-1:0]  msb_flip;

    // Operands shift left each cycle, so the digit under test is always the top one.
    assign dig_a    = a_q[WIDTH-1 -: DIGIT];
    assign dig_b    = b_q[WIDTH-1 -: DIGIT];
    assign differ   = (dig_a != dig_b);
    assign dig_gt   = (dig_a > dig_b);
    assign last     = (idx_q == '0);
    assign fin_diff = diff_q | differ;
    assign fin_gt   = diff_q ? sgt_q : dig_gt;
    // Offset-binary mapping turns a signed compare into an unsigned one.
    assign msb_flip = {signed_mode_i, {(WIDTH-1){1'b0}}};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        diff_d  = diff_q;
        sgt_d   = sgt_q;
        gt_d    = gt_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StCmp;
                    a_d     = a_i ^ msb_flip;
                    b_d     = b_i ^ msb_flip;
                    idx_d   = IdxW'(NDIG - 1);
                    diff_d  = 1'b0;
                    sgt_d   = 1'b0;
                end
            end
            StCmp: begin
                if ((EARLY_EXIT && differ) || last) begin
                    state_d = StDone;
                    gt_d    = fin_diff & fin_gt;
                    lt_d    = fin_diff & ~fin_gt;
                    eq_d    = ~fin_diff;
                end else begin
                    idx_d = idx_q - IdxW'(1);
                    a_d   = a_q << DIGIT;
                    b_d   = b_q << DIGIT;
                    if (!diff_q && differ) begin
                        diff_d = 1'b1;
                        sgt_d  = dig_gt;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            diff_q  <= 1'b0;
            sgt_q   <= 1'b0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            diff_q  <= diff_d;
            sgt_q   <= sgt_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
        end
    end

    assign busy_o = (state_q == StCmp);
    assign done_o = (state_q == StDone);
    assign gt_o   = gt_q;
    assign eq_o   = eq_q;
    assign lt_o   = lt_q;

endmodule

// File: tb/tb_seq_mag_comp.sv
// Directed bench for seq_mag_comp: early-exit and fixed-latency 8-bit instances plus a 1-bit one.
module tb_seq_mag_comp;

    localparam logic [2:0] GT = 3'b100;
    localparam logic [2:0] EQ = 3'b010;
    localparam logic [2:0] LT = 3'b001;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] start = '0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       a1 = 1'b0, b1 = 1'b0;
    logic       sm = 1'b0;
    logic [2:0] busy, done;
    logic [2:0] gt, eq, lt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_mag_comp #(.WIDTH(8), .DIGIT(2), .EARLY_EXIT(1'b1)) u_ee1 (
        .clk(clk), .rst_n(rst_n), .start_i(start[0]), .a_i(a8), .b_i(b8),
        .signed_mode_i(sm), .busy_o(busy[0]), .done_o(done[0]),
        .gt_o(gt[0]), .eq_o(eq[0]), .lt_o(lt[0])
    );

    seq_mag_comp #(.WIDTH(8), .DIGIT(2), .EARLY_EXIT(1'b0)) u_ee0 (
        .clk(clk), .rst_n(rst_n), .start_i(start[1]), .a_i(a8), .b_i(b8),
        .signed_mode_i(sm), .busy_o(busy[1]), .done_o(done[1]),
        .gt_o(gt[1]), .eq_o(eq[1]), .lt_o(lt[1])
    );

    seq_mag_comp #(.WIDTH(1), .DIGIT(1), .EARLY_EXIT(1'b1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .start_i(start[2]), .a_i(a1), .b_i(b1),
        .signed_mode_i(sm), .busy_o(busy[2]), .done_o(done[2]),
        .gt_o(gt[2]), .eq_o(eq[2]), .lt_o(lt[2])
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] flags(input int inst);
        return {gt[inst], eq[inst], lt[inst]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts busy cycles after the accepting edge, then checks done, flags and done falling.
    task automatic wait_done(input int inst, input string tag, input int exp_k,
                             input logic [2:0] exp_f);
        int cnt = 0;
        while (busy[inst] && cnt < 40) begin
            cnt++;
            step();
        end
        check({tag, " busy_cycles"}, cnt, exp_k);
        check({tag, " done"}, int'(done[inst]), 1);
        check({tag, " flags"}, int'(flags(inst)), int'(exp_f));
        step();
        check({tag, " done_pulse"}, int'(done[inst]), 0);
        check({tag, " flags_held"}, int'(flags(inst)), int'(exp_f));
    endtask

    task automatic run(input int inst, input string tag, input logic [7:0] av,
                       input logic [7:0] bv, input logic smv, input int exp_k,
                       input logic [2:0] exp_f);
        a8 = av;
        b8 = bv;
        a1 = av[0];
        b1 = bv[0];
        sm = smv;
        start[inst] = 1'b1;
        step();
        start[inst] = 1'b0;
        wait_done(inst, tag, exp_k, exp_f);
    endtask

    initial begin
        #12;
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset flags", int'({gt, eq, lt}), 0);
        rst_n = 1'b1;
        step();

        run(0, "ee1 00v00",  8'h00, 8'h00, 1'b0, 4, EQ);
        run(0, "ee1 C0v3F",  8'hC0, 8'h3F, 1'b0, 1, GT);
        run(0, "ee1 sC0v3F", 8'hC0, 8'h3F, 1'b1, 1, LT);
        run(0, "ee1 12v13",  8'h12, 8'h13, 1'b0, 4, LT);
        run(0, "ee1 s80v7F", 8'h80, 8'h7F, 1'b1, 1, LT);
        run(0, "ee1 sFFvFE", 8'hFF, 8'hFE, 1'b1, 4, GT);
        run(0, "ee1 34v24",  8'h34, 8'h24, 1'b0, 2, GT);
        run(0, "ee1 A5vA7",  8'hA5, 8'hA7, 1'b0, 4, LT);

        run(1, "ee0 C0v3F",  8'hC0, 8'h3F, 1'b0, 4, GT);
        run(1, "ee0 30v0C",  8'h30, 8'h0C, 1'b0, 4, GT);
        run(1, "ee0 12v13",  8'h12, 8'h13, 1'b0, 4, LT);
        run(1, "ee0 00v00",  8'h00, 8'h00, 1'b0, 4, EQ);

        run(2, "w1 1v0",     8'h01, 8'h00, 1'b0, 1, GT);
        run(2, "w1 0v1",     8'h00, 8'h01, 1'b0, 1, LT);
        run(2, "w1 1v1",     8'h01, 8'h01, 1'b0, 1, EQ);
        run(2, "w1 s1v0",    8'h01, 8'h00, 1'b1, 1, LT);
        run(2, "w1 s0v1",    8'h00, 8'h01, 1'b1, 1, GT);

        // start held high: operands change during CMP, re-accept only after the IDLE cycle.
        a8 = 8'h12; b8 = 8'h13; sm = 1'b0;
        start[0] = 1'b1;
        step();
        a8 = 8'h00; b8 = 8'h00;
        wait_done(0, "hold first", 4, LT);
        check("hold idle gap busy", int'(busy[0]), 0);
        step();
        check("hold reaccept busy", int'(busy[0]), 1);
        start[0] = 1'b0;
        wait_done(0, "hold second", 4, EQ);
        repeat (3) step();
        check("flags stable idle", int'(flags(0)), int'(EQ));

        // Asynchronous reset during the second CMP cycle.
        a8 = 8'h12; b8 = 8'h13; sm = 1'b0;
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        step();
        check("pre-reset busy", int'(busy[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid reset busy", int'(busy[0]), 0);
        check("mid reset done", int'(done[0]), 0);
        check("mid reset flags", int'(flags(0)), 0);
        step();
        rst_n = 1'b1;
        step();
        check("post reset idle", int'(busy[0]), 0);
        run(0, "post reset 05v09", 8'h05, 8'h09, 1'b0, 3, LT);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_mag_comp.md
Name: seq_mag_comp

Overview:
Parametrised, iterative magnitude comparator and the successor to the team's 1-bit combinational comparator. It compares two WIDTH-bit operands DIGIT bits per cycle, MSB-first, in unsigned or two's-complement signed mode. A start/busy/done handshake frames each comparison, and the comparison can terminate early at the first differing digit. It sits beside datapath blocks that need a gt/eq/lt decision without a wide combinational compare.

Parameters:
WIDTH, 8, operand width in bits (>=1)
DIGIT, 2, bits compared per cycle; WIDTH % DIGIT must be 0 (elaboration error otherwise); NDIG = WIDTH/DIGIT
EARLY_EXIT, 1, 1 = finish at the first differing digit; 0 = always run NDIG compare cycles (fixed latency)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
start  input  1  request; sampled only in IDLE
a  input  WIDTH  operand A; captured when start is accepted
b  input  WIDTH  operand B; captured when start is accepted
signed_mode  input  1  1 = two's complement; captured with the operands
busy  output  1  high while a comparison is in progress
done  output  1  one-cycle pulse when the result updates
gt  output  1  A > B
eq  output  1  A == B
lt  output  1  A < B

Behaviour:
- Clocking/reset: one clock, clk; rst_n is asynchronous and active-low.
- Reset values: state = IDLE; busy = 0, done = 0, gt = 0, eq = 0, lt = 0; internal operand registers and digit index = 0.
- FSM states: IDLE, CMP, DONE.
- IDLE -> CMP when start = 1 at a rising edge.
  - On that edge, capture a, b and signed_mode. Load digit index = NDIG-1 (most significant digit).
  - If signed_mode = 1, invert bit WIDTH-1 of both captured operands (offset-binary mapping). After that the compare is purely unsigned.
- CMP: each cycle compares digit[idx] of A against digit[idx] of B, DIGIT bits each, unsigned.
  - Digits differ and EARLY_EXIT = 1: at the edge, set gt/lt from that digit, eq = 0, go to DONE.
  - Digits differ and EARLY_EXIT = 0: record the first difference in a sticky register and keep going. Later digits do not alter the decision.
  - idx == 0 and this is the last digit: at the edge, write the flags (eq = 1 if no difference was recorded) and go to DONE.
  - Otherwise decrement idx and stay in CMP.
- DONE: lasts exactly one cycle with done = 1, then returns unconditionally to IDLE.
- busy = 1 exactly in CMP.
- Latency:
  - Measured from the start-accepting edge E0: busy is high for k cycles and done is high in cycle k+1.
  - k = NDIG when EARLY_EXIT = 0 or when the operands are equal.
  - k = (position of the first differing digit counted from the MSB, 1-based) when EARLY_EXIT = 1.
- Flags:
  - Registered. Exactly one of gt/eq/lt is 1 after the first done.
  - Held until overwritten at the next done; they are not cleared by start.
- Handshake:
  - start is ignored in CMP and DONE; no queueing.
  - The earliest next accept is the edge at the end of the DONE cycle's following IDLE cycle, so back-to-back throughput is k+2 cycles.
  - Changes on a, b or signed_mode after capture have no effect.
- Reset mid-operation: asynchronous return to IDLE, all outputs 0 immediately, captured operands discarded, no done pulse.
- Degenerate configurations:
  - WIDTH = 1, DIGIT = 1: a one-cycle CMP. Unsigned mode reproduces the legacy 1-bit comparator. In signed mode the inverted-MSB rule applies: 1 is -1, so it is less than 0.
  - DIGIT = WIDTH: single-cycle compare.

Test Plan:
- WIDTH=8, DIGIT=2, EARLY_EXIT=1; a=0x00, b=0x00, unsigned, start for 1 cycle -> busy for 4 cycles, done pulse in cycle 5; eq=1, gt=0, lt=0.
- Same config; a=0xC0, b=0x3F, unsigned -> busy 1 cycle, done in cycle 2, gt=1. Repeat with signed_mode=1 (-64 vs 63) -> lt=1, same latency.
- Same config; a=0x12, b=0x13 -> lt=1 after 4 busy cycles. Signed a=0x80, b=0x7F -> lt=1 after 1 cycle. Signed a=0xFF, b=0xFE -> gt=1 after 4 cycles.
- EARLY_EXIT=0 instance; a=0xC0, b=0x3F -> busy exactly 4 cycles, gt=1. The later differing digits (0 vs 3 in digit 0) must not flip the result.
- Start held high continuously, and operands changed during CMP -> only one capture per IDLE; the result reflects the captured values; the next accept follows IDLE; flags stay stable between done pulses.
- rst_n driven low during the 2nd CMP cycle of a 4-cycle compare -> busy, done and all flags 0 immediately, state IDLE. After release, a fresh start with a=0x05, b=0x09 -> lt=1, normal latency.
